// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM states and the 10-bit duty
// format that the PWM generator also uses.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cap_state_e;

  localparam int unsigned DUTY_BITS       = 10;
  localparam int unsigned DUTY_FRAC_BITS  = 2;
  localparam int unsigned DUTY_WHOLE_BITS = DUTY_BITS - DUTY_FRAC_BITS;
  localparam logic [DUTY_BITS-1:0] DUTY_MAX = 10'h3FC;

  // Fractional bits stay zero: single-rate capture cannot see half-cycles.
  function automatic logic [DUTY_BITS-1:0] duty_format(
    input logic                       sat,
    input logic [DUTY_WHOLE_BITS-1:0] whole
  );
    if (sat) return DUTY_MAX;
    return {whole, {DUTY_FRAC_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement result bundle produced by pwm_capture.
interface pwm_capture_if #(
  parameter int unsigned CNT_BITS = 16
);
  import pwm_capture_pkg::*;

  logic [CNT_BITS-1:0]  high_count;
  logic [CNT_BITS:0]    period_count;
  logic [DUTY_BITS-1:0] duty_cycle;
  logic                 period_match;
  logic                 valid;
  logic                 stuck;
  logic                 stuck_level;

  modport master (
    output high_count, period_count, duty_cycle, period_match,
           valid, stuck, stuck_level
  );

  modport slave (
    input high_count, period_count, duty_cycle, period_match,
          valid, stuck, stuck_level
  );

endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin followed by edge detection.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an external PWM pin in clk cycles and
// flags a pin that stops toggling.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_BITS    = 16,
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned PERIOD_LOG2 = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pwm_in,
  pwm_capture_if.master  cap
);

  localparam logic [CNT_BITS-1:0] TIMEOUT_CNT = CNT_BITS'(TIMEOUT);
  localparam logic [CNT_BITS-1:0] DUTY_SAT_LIM = CNT_BITS'(255);
  localparam logic [CNT_BITS:0]   PERIOD_NOM  = (CNT_BITS+1)'(1) << PERIOD_LOG2;

  logic level;
  logic rise;
  logic fall;

  pwm_sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  cap_state_e          state;
  cap_state_e          state_next;
  logic [CNT_BITS-1:0] hcnt;
  logic [CNT_BITS-1:0] hcnt_next;
  logic [CNT_BITS-1:0] lcnt;
  logic [CNT_BITS-1:0] lcnt_next;
  logic                capture;
  logic                timeout;
  logic                stuck_clear;
  logic [CNT_BITS:0]   period_sum;

  assign period_sum = {1'b0, hcnt} + {1'b0, lcnt};

  // An edge wins over a coincident timeout, so edges are tested first.
  always_comb begin
    state_next  = state;
    hcnt_next   = hcnt;
    lcnt_next   = lcnt;
    capture     = 1'b0;
    timeout     = 1'b0;
    stuck_clear = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rise) begin
          hcnt_next   = CNT_BITS'(1);
          state_next  = ST_HIGH;
          stuck_clear = 1'b1;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          lcnt_next  = CNT_BITS'(1);
          state_next = ST_LOW;
        end else if (hcnt == TIMEOUT_CNT) begin
          state_next = ST_IDLE;
          timeout    = 1'b1;
        end else begin
          hcnt_next = hcnt + CNT_BITS'(1);
        end
      end
      ST_LOW: begin
        if (rise) begin
          capture    = 1'b1;
          hcnt_next  = CNT_BITS'(1);
          state_next = ST_HIGH;
        end else if (lcnt == TIMEOUT_CNT) begin
          state_next = ST_IDLE;
          timeout    = 1'b1;
        end else begin
          lcnt_next = lcnt + CNT_BITS'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      hcnt             <= '0;
      lcnt             <= '0;
      cap.high_count   <= '0;
      cap.period_count <= '0;
      cap.duty_cycle   <= '0;
      cap.period_match <= 1'b0;
      cap.valid        <= 1'b0;
      cap.stuck        <= 1'b0;
      cap.stuck_level  <= 1'b0;
    end else begin
      state     <= state_next;
      hcnt      <= hcnt_next;
      lcnt      <= lcnt_next;
      cap.valid <= capture;
      if (capture) begin
        cap.high_count   <= hcnt;
        cap.period_count <= period_sum;
        cap.duty_cycle   <= duty_format(hcnt > DUTY_SAT_LIM, hcnt[DUTY_WHOLE_BITS-1:0]);
        cap.period_match <= (period_sum == PERIOD_NOM);
      end
      // No edge since entering HIGH/LOW, so the synced level is that state's level.
      if (timeout) begin
        cap.stuck       <= 1'b1;
        cap.stuck_level <= level;
      end else if (stuck_clear) begin
        cap.stuck <= 1'b0;
      end
    end
  end

endmodule
